seq_mul_unit: RTL

//  Iterative shift-add multiplier, parametrised in operand width, with a start/busy/done handshake.

---
 rtl/mul_pkg.sv | 23 ++
 rtl/seq_mul_dp.sv | 104 ++++++++++
 rtl/seq_mul_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and constants for the sequential multiplier:
//               FSM state encoding and the control-unit opcodes that lead
//               to a multiply start.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Multiplier controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Opcodes decoded by the control unit to issue start / read the product
  localparam logic [5:0] MUL = 6'b011001;
  localparam logic [5:0] OUT = 6'b111111;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/seq_mul_dp.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_dp
// Description : Shift-add multiplier datapath. Holds the multiplicand,
//               multiplier and partial-product registers, the 2*WIDTH adder,
//               the operand magnitude logic and the final negate.
//               Signed support is compiled in with the MUL_SIGNED_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_dp
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,       // accepted start: capture operands
  input  logic               step_i,       // one shift-add iteration
  input  logic               finish_i,     // capture the final product
  input  logic               signed_op_i,
  input  logic [WIDTH-1:0]   data_a_i,
  input  logic [WIDTH-1:0]   data_b_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [2*WIDTH-1:0] mcnd_q, mcnd_d;
  logic [WIDTH-1:0]   mpy_q,  mpy_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] out_q,  out_d;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_result;

`ifdef MUL_SIGNED_EN
  logic neg_q;
  logic w_neg;

  // Magnitudes as unsigned W-bit values; the most negative input maps to 2^(W-1)
  assign w_abs_a = (signed_op_i && data_a_i[WIDTH-1]) ? (-data_a_i) : data_a_i;
  assign w_abs_b = (signed_op_i && data_b_i[WIDTH-1]) ? (-data_b_i) : data_b_i;
  assign w_neg   = signed_op_i & (data_a_i[WIDTH-1] ^ data_b_i[WIDTH-1]);

  // Negating in full product width keeps a zero product at zero
  assign w_result = neg_q ? (-prod_q) : prod_q;

  // Result sign captured with the operands
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else if (load_i) begin
      neg_q <= w_neg;
    end
  end
`else
  logic w_unused_signed;

  assign w_abs_a         = data_a_i;
  assign w_abs_b         = data_b_i;
  assign w_result        = prod_q;
  assign w_unused_signed = signed_op_i;
`endif

  // Next-state for operand/product registers: load, iterate or capture
  always_comb begin
    mcnd_d = mcnd_q;
    mpy_d  = mpy_q;
    prod_d = prod_q;
    out_d  = out_q;
    if (load_i) begin
      mcnd_d = {{WIDTH{1'b0}}, w_abs_a};
      mpy_d  = w_abs_b;
      prod_d = '0;
    end else if (step_i) begin
      if (mpy_q[0]) begin
        prod_d = prod_q + mcnd_q;
      end
      mcnd_d = mcnd_q << 1;
      mpy_d  = mpy_q >> 1;
    end
    if (finish_i) begin
      out_d = w_result;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mcnd_q <= '0;
      mpy_q  <= '0;
      prod_q <= '0;
      out_q  <= '0;
    end else begin
      mcnd_q <= mcnd_d;
      mpy_q  <= mpy_d;
      prod_q <= prod_d;
      out_q  <= out_d;
    end
  end

  assign product_o = out_q;

endmodule : seq_mul_dp
`default_nettype wire

// File: rtl/seq_mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_unit
// Description : Iterative shift-add multiplier with start/busy/done
//               handshake. Fixed latency of WIDTH+1 cycles from the
//               accepting edge to the done pulse. Unsigned by default;
//               signed two's-complement mode enabled by MUL_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signedOp,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] dataOut
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic w_load;
  logic w_step;
  logic w_finish;

  // Start is only honoured in IDLE; RUN iterates until the counter has
  // drained, then spends one more RUN cycle capturing the result.
  assign w_load   = (state_q == IDLE) && start;
  assign w_step   = (state_q == RUN) && (cnt_q != '0);
  assign w_finish = (state_q == RUN) && (cnt_q == '0);

  // Controller FSM with registered busy/done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  seq_mul_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk         (clk),
    .reset       (reset),
    .load_i      (w_load),
    .step_i      (w_step),
    .finish_i    (w_finish),
    .signed_op_i (signedOp),
    .data_a_i    (dataA),
    .data_b_i    (dataB),
    .product_o   (dataOut)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule : seq_mul_unit
`default_nettype wire
